// File: rtl/noc_params.sv
// Shared router constants and types: port/VC counts, index widths and port ids.
package noc_params;

    localparam int PORT_NUM  = 5;
    localparam int VC_NUM    = 2;
    localparam int PORT_SIZE = $clog2(PORT_NUM);
    localparam int VC_SIZE   = $clog2(VC_NUM);

    // Port 0 is the highest priority after reset.
    typedef enum logic [PORT_SIZE-1:0] {
        NORTH = 3'd0,
        SOUTH = 3'd1,
        WEST  = 3'd2,
        EAST  = 3'd3,
        LOCAL = 3'd4
    } port_t;

    // True when the encoding names a real port (guards the unused codes).
    function automatic logic port_valid(input port_t p);
        return (p == NORTH) || (p == SOUTH) || (p == WEST) || (p == EAST) || (p == LOCAL);
    endfunction

endpackage

// File: rtl/round_robin_arbiter.sv
// N-way round-robin arbiter. The pointer marks the highest-priority index and
// moves one past the winner only when the caller confirms the grant was used.
module round_robin_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] request_i,
    input  logic         update_i,
    output logic [N-1:0] grant_o
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] ptr_r;
    logic [PTR_W-1:0] win_idx_s;
    logic [PTR_W-1:0] ptr_next_s;
    logic             found_s;
    logic [PTR_W:0]   sum_s;
    logic [PTR_W:0]   idx_s;
    logic             hit_s;

    // Scan from the pointer, wrapping once, and grant the first requester.
    always_comb begin
        grant_o   = '0;
        win_idx_s = '0;
        found_s   = 1'b0;
        sum_s     = '0;
        idx_s     = '0;
        hit_s     = 1'b0;
        for (int k = 0; k < N; k++) begin
            sum_s     = {1'b0, ptr_r} + (PTR_W + 1)'(k);
            idx_s     = (sum_s >= (PTR_W + 1)'(N)) ? (sum_s - (PTR_W + 1)'(N)) : sum_s;
            hit_s     = !found_s && request_i[idx_s[PTR_W-1:0]];
            grant_o[idx_s[PTR_W-1:0]] = hit_s;
            win_idx_s = hit_s ? idx_s[PTR_W-1:0] : win_idx_s;
            found_s   = found_s | hit_s;
        end
    end

    // Position just past the winner, wrapping N-1 back to 0.
    always_comb begin
        ptr_next_s = (win_idx_s == PTR_W'(N - 1)) ? '0 : (win_idx_s + PTR_W'(1));
    end

    // Pointer register: moves only on a confirmed grant, otherwise holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r <= '0;
        end else if (update_i && found_s) begin
            ptr_r <= ptr_next_s;
        end else begin
            ptr_r <= ptr_r;
        end
    end

endmodule

// File: rtl/switch_allocator_checker.sv
// Grant invariants of the switch allocator, kept apart from the datapath.
module switch_allocator_checker
    import noc_params::*;
(
    input logic                               clk,
    input logic                               rst,
    input logic [PORT_NUM-1:0][VC_NUM-1:0]    read_o,
    input logic [PORT_NUM-1:0]                valid_sel_o,
    input logic [PORT_NUM-1:0][PORT_NUM-1:0]  out_grant
);

    for (genvar i = 0; i < PORT_NUM; i++) begin : g_in
        a_read_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(read_o[i]));
    end

    for (genvar p = 0; p < PORT_NUM; p++) begin : g_out
        a_out_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(out_grant[p]));
    end

    a_read_eq_valid: assert property (@(posedge clk) disable iff (rst)
        $countones(read_o) == $countones(valid_sel_o));

endmodule

// File: rtl/switch_allocator.sv
// Separable input-first round-robin switch allocator. Stage 1 picks one
// eligible VC per input, stage 2 picks one input per output; the result is
// registered and drives buffer reads and crossbar selects one cycle later.
module switch_allocator
    import noc_params::*;
(
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic  [PORT_NUM-1:0][VC_NUM-1:0]             request_i,
    input  port_t [PORT_NUM-1:0][VC_NUM-1:0]             out_port_i,
    input  logic  [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0] downstream_vc_i,
    input  logic  [PORT_NUM-1:0][VC_NUM-1:0]             on_off_i,
    output logic  [PORT_NUM-1:0][VC_NUM-1:0]             read_o,
    output logic  [PORT_NUM-1:0]                         valid_sel_o,
    output logic  [PORT_NUM-1:0][PORT_SIZE-1:0]          input_sel_o,
    output logic  [PORT_NUM-1:0][VC_SIZE-1:0]            vc_sel_o
);

    logic  [PORT_NUM-1:0][VC_NUM-1:0]    eligible_s;
    logic  [PORT_NUM-1:0][VC_NUM-1:0]    vc_grant_s;
    logic  [PORT_NUM-1:0]                in_valid_s;
    port_t [PORT_NUM-1:0]                in_port_s;
    logic  [PORT_NUM-1:0][VC_SIZE-1:0]   in_dvc_s;
    logic  [PORT_NUM-1:0][PORT_NUM-1:0]  out_req_s;     // [output][input]
    logic  [PORT_NUM-1:0][PORT_NUM-1:0]  out_grant_s;   // [output][input]
    logic  [PORT_NUM-1:0]                in_win_s;

    logic  [PORT_NUM-1:0][VC_NUM-1:0]    read_d_s;
    logic  [PORT_NUM-1:0]                valid_d_s;
    logic  [PORT_NUM-1:0][PORT_SIZE-1:0] isel_d_s;
    logic  [PORT_NUM-1:0][VC_SIZE-1:0]   vsel_d_s;

    logic  [PORT_NUM-1:0][VC_NUM-1:0]    read_r;
    logic  [PORT_NUM-1:0]                valid_r;
    logic  [PORT_NUM-1:0][PORT_SIZE-1:0] isel_r;
    logic  [PORT_NUM-1:0][VC_SIZE-1:0]   vsel_r;

    // A VC competes only if it has a flit and its downstream VC is switched on.
    always_comb begin
        eligible_s = '0;
        for (int i = 0; i < PORT_NUM; i++) begin
            for (int v = 0; v < VC_NUM; v++) begin
                if (request_i[i][v] && port_valid(out_port_i[i][v])) begin
                    eligible_s[i][v] = on_off_i[out_port_i[i][v]][downstream_vc_i[i][v]];
                end else begin
                    eligible_s[i][v] = 1'b0;
                end
            end
        end
    end

    // Stage 1: one VC arbiter per input; pointer moves only when stage 2 also grants.
    for (genvar i = 0; i < PORT_NUM; i++) begin : g_in_arb
        round_robin_arbiter #(.N(VC_NUM)) u_in_arb (
            .clk       (clk),
            .rst       (rst),
            .request_i (eligible_s[i]),
            .update_i  (in_win_s[i]),
            .grant_o   (vc_grant_s[i])
        );
    end

    // Decode each stage-1 winner into its target output and downstream VC.
    always_comb begin
        in_valid_s = '0;
        in_port_s  = '{default: NORTH};
        in_dvc_s   = '0;
        for (int i = 0; i < PORT_NUM; i++) begin
            for (int v = 0; v < VC_NUM; v++) begin
                in_valid_s[i] = in_valid_s[i] | vc_grant_s[i][v];
                in_port_s[i]  = vc_grant_s[i][v] ? out_port_i[i][v] : in_port_s[i];
                in_dvc_s[i]   = vc_grant_s[i][v] ? downstream_vc_i[i][v] : in_dvc_s[i];
            end
        end
    end

    // Route each stage-1 winner's request to the output it targets.
    always_comb begin
        out_req_s = '0;
        for (int p = 0; p < PORT_NUM; p++) begin
            for (int i = 0; i < PORT_NUM; i++) begin
                out_req_s[p][i] = in_valid_s[i] && (in_port_s[i] == PORT_SIZE'(p));
            end
        end
    end

    // Stage 2: one input arbiter per output; it advances whenever it grants.
    for (genvar p = 0; p < PORT_NUM; p++) begin : g_out_arb
        round_robin_arbiter #(.N(PORT_NUM)) u_out_arb (
            .clk       (clk),
            .rst       (rst),
            .request_i (out_req_s[p]),
            .update_i  (1'b1),
            .grant_o   (out_grant_s[p])
        );
    end

    // An input won if any output arbiter granted it.
    always_comb begin
        in_win_s = '0;
        for (int i = 0; i < PORT_NUM; i++) begin
            for (int p = 0; p < PORT_NUM; p++) begin
                in_win_s[i] = in_win_s[i] | out_grant_s[p][i];
            end
        end
    end

    // Final grants: read strobe for the winning VC, crossbar and VC selects per output.
    always_comb begin
        read_d_s  = '0;
        valid_d_s = '0;
        isel_d_s  = '0;
        vsel_d_s  = '0;
        for (int i = 0; i < PORT_NUM; i++) begin
            read_d_s[i] = vc_grant_s[i] & {VC_NUM{in_win_s[i]}};
        end
        for (int p = 0; p < PORT_NUM; p++) begin
            valid_d_s[p] = |out_grant_s[p];
            for (int i = 0; i < PORT_NUM; i++) begin
                isel_d_s[p] = out_grant_s[p][i] ? PORT_SIZE'(i) : isel_d_s[p];
                vsel_d_s[p] = out_grant_s[p][i] ? in_dvc_s[i] : vsel_d_s[p];
            end
        end
    end

    // Output registers: one-cycle grant latency, cleared immediately on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_r  <= '0;
            valid_r <= '0;
            isel_r  <= '0;
            vsel_r  <= '0;
        end else begin
            read_r  <= read_d_s;
            valid_r <= valid_d_s;
            isel_r  <= isel_d_s;
            vsel_r  <= vsel_d_s;
        end
    end

    assign read_o      = read_r;
    assign valid_sel_o = valid_r;
    assign input_sel_o = isel_r;
    assign vc_sel_o    = vsel_r;

    switch_allocator_checker u_checker (
        .clk         (clk),
        .rst         (rst),
        .read_o      (read_r),
        .valid_sel_o (valid_r),
        .out_grant   (out_grant_s)
    );

endmodule

// File: tb/tb_switch_allocator.sv
// Bench for switch_allocator: directed table, multi-cycle corner sequences,
// and random traffic checked against an arbitration model.
module tb_switch_allocator;
    import noc_params::*;

    logic clk = 1'b0;
    logic rst;
    logic  [PORT_NUM-1:0][VC_NUM-1:0]              request;
    port_t [PORT_NUM-1:0][VC_NUM-1:0]              out_port;
    logic  [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0] dvc;
    logic  [PORT_NUM-1:0][VC_NUM-1:0]              on_off;
    logic  [PORT_NUM-1:0][VC_NUM-1:0]              read;
    logic  [PORT_NUM-1:0]                          valid_sel;
    logic  [PORT_NUM-1:0][PORT_SIZE-1:0]           input_sel;
    logic  [PORT_NUM-1:0][VC_SIZE-1:0]             vc_sel;

    int checks = 0;
    int errors = 0;

    // Model state and expectations
    int iptr [PORT_NUM];
    int optr [PORT_NUM];
    logic [PORT_NUM-1:0][VC_NUM-1:0]    e_read;
    logic [PORT_NUM-1:0]                e_valid;
    logic [PORT_NUM-1:0][PORT_SIZE-1:0] e_isel;
    logic [PORT_NUM-1:0][VC_SIZE-1:0]   e_vsel;

    typedef struct {
        string                                         name;
        logic [PORT_NUM-1:0][VC_NUM-1:0]               req;
        logic [PORT_NUM-1:0][VC_NUM-1:0]               onoff;
        logic [PORT_NUM-1:0][VC_NUM-1:0][PORT_SIZE-1:0] op;
        logic [PORT_NUM-1:0][VC_NUM-1:0][VC_SIZE-1:0]  dv;
        logic [PORT_NUM-1:0][VC_NUM-1:0]               x_read;
        logic [PORT_NUM-1:0]                           x_valid;
        logic [PORT_NUM-1:0][PORT_SIZE-1:0]            x_isel;
        logic [PORT_NUM-1:0][VC_SIZE-1:0]              x_vsel;
    } vec_t;

    vec_t tbl [7];
    int   order [3] = '{0, 1, 3};

    switch_allocator dut (
        .clk             (clk),
        .rst             (rst),
        .request_i       (request),
        .out_port_i      (out_port),
        .downstream_vc_i (dvc),
        .on_off_i        (on_off),
        .read_o          (read),
        .valid_sel_o     (valid_sel),
        .input_sel_o     (input_sel),
        .vc_sel_o        (vc_sel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        request = '0;
        on_off  = '1;
        dvc     = '0;
        for (int i = 0; i < PORT_NUM; i++)
            for (int v = 0; v < VC_NUM; v++)
                out_port[i][v] = NORTH;
    endtask

    task automatic model_reset();
        for (int i = 0; i < PORT_NUM; i++) begin
            iptr[i] = 0;
            optr[i] = 0;
        end
    endtask

    // Input-first separable allocation from the rules: pick per input, then per output.
    task automatic model_step();
        int s1 [PORT_NUM];
        int s2 [PORT_NUM];
        e_read = '0; e_valid = '0; e_isel = '0; e_vsel = '0;
        for (int i = 0; i < PORT_NUM; i++) begin
            s1[i] = -1;
            for (int k = 0; k < VC_NUM; k++) begin
                int v;
                v = (iptr[i] + k) % VC_NUM;
                if (s1[i] < 0 && request[i][v] && on_off[out_port[i][v]][dvc[i][v]]) s1[i] = v;
            end
        end
        for (int p = 0; p < PORT_NUM; p++) begin
            s2[p] = -1;
            for (int k = 0; k < PORT_NUM; k++) begin
                int i;
                i = (optr[p] + k) % PORT_NUM;
                if (s2[p] < 0 && s1[i] >= 0 && int'(out_port[i][s1[i]]) == p) s2[p] = i;
            end
        end
        for (int p = 0; p < PORT_NUM; p++) begin
            if (s2[p] >= 0) begin
                int i;
                i = s2[p];
                e_read[i][s1[i]] = 1'b1;
                e_valid[p] = 1'b1;
                e_isel[p]  = PORT_SIZE'(i);
                e_vsel[p]  = dvc[i][s1[i]];
                optr[p] = (i + 1) % PORT_NUM;
                iptr[i] = (s1[i] + 1) % VC_NUM;
            end
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".read"},  32'(read),      32'd0);
        chk({tag, ".valid"}, 32'(valid_sel), 32'd0);
        chk({tag, ".isel"},  32'(input_sel), 32'd0);
        chk({tag, ".vsel"},  32'(vc_sel),    32'd0);
    endtask

    task automatic model_cycle(input string tag);
        model_step();
        @(posedge clk);
        #1;
        chk({tag, ".read"},  32'(read),      32'(e_read));
        chk({tag, ".valid"}, 32'(valid_sel), 32'(e_valid));
        chk({tag, ".isel"},  32'(input_sel), 32'(e_isel));
        chk({tag, ".vsel"},  32'(vc_sel),    32'(e_vsel));
    endtask

    // Leaves time at posedge+1 with rst released and pointers at 0.
    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---------------- table ----------------
        for (int k = 0; k < 7; k++) begin
            tbl[k].req = '0; tbl[k].onoff = '1; tbl[k].op = '0; tbl[k].dv = '0;
            tbl[k].x_read = '0; tbl[k].x_valid = '0; tbl[k].x_isel = '0; tbl[k].x_vsel = '0;
        end
        tbl[0].name = "single";
        tbl[0].req[2][1] = 1'b1; tbl[0].op[2][1] = 3'd0;
        tbl[0].x_read[2] = 2'b10; tbl[0].x_valid[0] = 1'b1; tbl[0].x_isel[0] = 3'd2;
        tbl[1].name = "uturn";
        tbl[1].req[4][0] = 1'b1; tbl[1].op[4][0] = 3'd4; tbl[1].dv[4][0] = 1'b1;
        tbl[1].x_read[4] = 2'b01; tbl[1].x_valid[4] = 1'b1; tbl[1].x_isel[4] = 3'd4; tbl[1].x_vsel[4] = 1'b1;
        tbl[2].name = "masked";
        tbl[2].req[1][0] = 1'b1; tbl[2].op[1][0] = 3'd2; tbl[2].dv[1][0] = 1'b1; tbl[2].onoff[2][1] = 1'b0;
        tbl[3].name = "contend";
        tbl[3].req[0][0] = 1'b1; tbl[3].op[0][0] = 3'd4; tbl[3].req[3][0] = 1'b1; tbl[3].op[3][0] = 3'd4;
        tbl[3].x_read[0] = 2'b01; tbl[3].x_valid[4] = 1'b1; tbl[3].x_isel[4] = 3'd0;
        tbl[4].name = "bothvc";
        tbl[4].req[2] = 2'b11; tbl[4].op[2][0] = 3'd3; tbl[4].dv[2][0] = 1'b1; tbl[4].op[2][1] = 3'd0;
        tbl[4].x_read[2] = 2'b01; tbl[4].x_valid[3] = 1'b1; tbl[4].x_isel[3] = 3'd2; tbl[4].x_vsel[3] = 1'b1;
        tbl[5].name = "idle";
        tbl[6].name = "parallel";
        tbl[6].req[0][1] = 1'b1; tbl[6].op[0][1] = 3'd1; tbl[6].dv[0][1] = 1'b1;
        tbl[6].req[3][0] = 1'b1; tbl[6].op[3][0] = 3'd2;
        tbl[6].x_read[0] = 2'b10; tbl[6].x_read[3] = 2'b01; tbl[6].x_valid[1] = 1'b1; tbl[6].x_valid[2] = 1'b1;
        tbl[6].x_isel[1] = 3'd0; tbl[6].x_isel[2] = 3'd3; tbl[6].x_vsel[1] = 1'b1;

        // ---------------- reset state ----------------
        rst = 1'b1;
        clear_inputs();
        model_reset();
        #1;
        check_zero("reset");
        tick();
        rst = 1'b0;

        for (int k = 0; k < 7; k++) begin
            do_reset();
            request = tbl[k].req;
            on_off  = tbl[k].onoff;
            dvc     = tbl[k].dv;
            for (int i = 0; i < PORT_NUM; i++)
                for (int v = 0; v < VC_NUM; v++)
                    out_port[i][v] = port_t'(tbl[k].op[i][v]);
            tick();
            chk({tbl[k].name, ".read"},  32'(read),      32'(tbl[k].x_read));
            chk({tbl[k].name, ".valid"}, 32'(valid_sel), 32'(tbl[k].x_valid));
            chk({tbl[k].name, ".isel"},  32'(input_sel), 32'(tbl[k].x_isel));
            chk({tbl[k].name, ".vsel"},  32'(vc_sel),    32'(tbl[k].x_vsel));
        end

        // ---------------- output contention rotation ----------------
        do_reset();
        request[NORTH][0] = 1'b1; out_port[NORTH][0] = LOCAL;
        request[SOUTH][0] = 1'b1; out_port[SOUTH][0] = LOCAL;
        request[EAST][0]  = 1'b1; out_port[EAST][0]  = LOCAL;
        for (int c = 0; c < 6; c++) begin
            tick();
            chk("rot.valid", 32'(valid_sel), 32'h10);
            chk("rot.isel",  32'(input_sel[LOCAL]), 32'(order[c % 3]));
            chk("rot.reads", 32'($countones(read)), 32'd1);
        end

        // ---------------- VC contention alternation ----------------
        do_reset();
        request[WEST] = 2'b11;
        out_port[WEST][0] = EAST;
        out_port[WEST][1] = NORTH;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("vcalt.read",  32'(read[WEST]), (c % 2 == 0) ? 32'h1 : 32'h2);
            chk("vcalt.valid", 32'(valid_sel),  (c % 2 == 0) ? 32'h08 : 32'h01);
        end

        // ---------------- flow control hold-off ----------------
        do_reset();
        request[SOUTH][0] = 1'b1; out_port[SOUTH][0] = WEST; dvc[SOUTH][0] = 1'b1;
        on_off[WEST][1] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("fc.off.valid", 32'(valid_sel), 32'd0);
            chk("fc.off.read",  32'(read),      32'd0);
        end
        on_off[WEST][1] = 1'b1;
        tick();
        chk("fc.on.read",  32'(read[SOUTH]),     32'h1);
        chk("fc.on.valid", 32'(valid_sel),       32'h04);
        chk("fc.on.isel",  32'(input_sel[WEST]), 32'(SOUTH));
        chk("fc.on.vsel",  32'(vc_sel[WEST]),    32'h1);

        // ---------------- iSLIP pointer hold ----------------
        do_reset();
        request[NORTH][0] = 1'b1; out_port[NORTH][0] = LOCAL;
        request[WEST]     = 2'b11;
        out_port[WEST][0] = LOCAL;
        out_port[WEST][1] = SOUTH;
        tick();
        chk("islip1.read",  32'(read[WEST]),      32'h0);
        chk("islip1.valid", 32'(valid_sel),       32'h10);
        chk("islip1.isel",  32'(input_sel[LOCAL]), 32'(NORTH));
        tick();
        chk("islip2.read",  32'(read[WEST]),      32'h1);
        chk("islip2.valid", 32'(valid_sel),       32'h10);
        chk("islip2.isel",  32'(input_sel[LOCAL]), 32'(WEST));
        tick();
        chk("islip3.read",  32'(read[WEST]),      32'h2);
        chk("islip3.valid", 32'(valid_sel),       32'h12);
        chk("islip3.isel",  32'(input_sel[LOCAL]), 32'(NORTH));

        // ---------------- reset mid-stream ----------------
        do_reset();
        request[NORTH][0] = 1'b1; out_port[NORTH][0] = LOCAL;
        request[SOUTH][0] = 1'b1; out_port[SOUTH][0] = LOCAL;
        request[EAST][0]  = 1'b1; out_port[EAST][0]  = LOCAL;
        tick();
        tick();
        chk("mid.pre.isel", 32'(input_sel[LOCAL]), 32'(SOUTH));
        #2;
        rst = 1'b1;
        #1;
        check_zero("mid.async");
        tick();
        rst = 1'b0;
        tick();
        chk("mid.post1.isel",  32'(input_sel[LOCAL]), 32'(NORTH));
        chk("mid.post1.valid", 32'(valid_sel),        32'h10);
        tick();
        chk("mid.post2.isel",  32'(input_sel[LOCAL]), 32'(SOUTH));

        // ---------------- random traffic vs model ----------------
        do_reset();
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) != 0) begin
                for (int i = 0; i < PORT_NUM; i++) begin
                    for (int v = 0; v < VC_NUM; v++) begin
                        request[i][v]  = ($urandom_range(0, 99) < 50);
                        out_port[i][v] = port_t'($urandom_range(0, PORT_NUM - 1));
                        dvc[i][v]      = VC_SIZE'($urandom_range(0, VC_NUM - 1));
                        on_off[i][v]   = ($urandom_range(0, 99) < 80);
                    end
                end
            end
            model_cycle("rand");
            if (n % 97 == 50) begin
                rst = 1'b1;
                #1;
                check_zero("rand.rst");
                model_reset();
                tick();
                rst = 1'b0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/switch_allocator.md
# switch_allocator

Separable input-first round-robin switch allocator for the router. It takes per-VC flit-ready requests from the input buffers and the downstream on/off flow-control state. Each cycle it grants at most one VC per input port and at most one input port per output port. The grants drive the input buffers' read strobes and the crossbar select lines. It sits between the input ports (input buffers plus VC allocation) and the crossbar.

## Interface
- PORT_NUM, 5, number of router ports (NORTH, SOUTH, WEST, EAST, LOCAL as in noc_params)
- VC_NUM, 2, virtual channels per port
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- request_i  in  [PORT_NUM][VC_NUM]  input VC holds a flit and already has a downstream VC
- out_port_i  in  [PORT_NUM][VC_NUM] port_t  routed output port of that VC's packet
- downstream_vc_i  in  [PORT_NUM][VC_NUM][VC_SIZE]  downstream VC allocated to that input VC
- on_off_i  in  [PORT_NUM][VC_NUM]  downstream VC of output port p may accept a flit (1 = on)
- read_o  out  [PORT_NUM][VC_NUM]  one-hot-or-zero per input port; pulses the input buffer read_i
- valid_sel_o  out  [PORT_NUM]  output port p carries a flit this cycle
- input_sel_o  out  [PORT_NUM][PORT_SIZE]  crossbar select: input port driving output p
- vc_sel_o  out  [PORT_NUM][VC_SIZE]  downstream VC id stamped on the flit leaving output p

## Operation
- Eligibility: VC (i,v) is eligible iff request_i[i][v] && on_off_i[out_port_i[i][v]][downstream_vc_i[i][v]].
- Stage 1, input arbitration: per input port i, a VC_NUM-way round-robin arbiter picks one eligible VC. The winner forwards a request to out_port_i of that VC.
- Stage 2, output arbitration: per output port p, a PORT_NUM-way round-robin arbiter picks one input among the stage-1 winners targeting p.
- Final grant (i,v,p): read_o[i][v]=1, valid_sel_o[p]=1, input_sel_o[p]=i, vc_sel_o[p]=downstream_vc_i[i][v].
- Pointer update, iSLIP-style:
  - output arbiter p advances to (winner+1) mod PORT_NUM only when it grants;
  - input arbiter i advances to (v+1) mod VC_NUM only when its stage-1 winner also wins stage 2.
  - Losing arbiters hold their pointer.
- Stateless beyond pointers: no flit counting. A request held across cycles is re-arbitrated every cycle. Each grant equals exactly one flit read.
- Invariants, checked by assertions:
  - at most one read_o bit per input port;
  - at most one grant per output port;
  - sum of read_o bits equals the count of valid_sel_o bits.
- U-turns (out_port_i == own input port) are allowed and arbitrated normally.

## Timing
- Eligibility and both arbitration stages are combinational from the current-cycle inputs. Outputs are registered: a request seen at posedge t gives a grant at posedge t+1 (1-cycle latency).
- Pointers update on the same edge that registers the grant.
- Reset (async assert, any time including mid-operation):
  - read_o, valid_sel_o, input_sel_o and vc_sel_o go to 0 immediately;
  - all pointers go to 0 (index 0 highest priority).
  - First grant is possible at the first posedge after rst deasserts.
- on_off_i dropping in cycle t masks grants registered at t+1. A grant already registered is not revoked.
- All request bits zero: outputs 0 next cycle, pointers unchanged.
- Pointer wrap: PORT_NUM-1 → 0 and VC_NUM-1 → 0.
- A stage-1 winner that loses stage 2 is retried next cycle. Its other VC is not substituted in the same cycle.

## Structure
- Shared constants and types come from noc_params: PORT_NUM, VC_NUM, VC_SIZE, PORT_SIZE, port_t.
- Sub-module round_robin_arbiter #(N): inputs clk, rst, request_i[N], update_i. Output grant_o[N], one-hot or zero. The pointer register lives internally and advances past the grant when update_i=1.
  - Instantiated PORT_NUM times with N=VC_NUM (stage 1).
  - Instantiated PORT_NUM times with N=PORT_NUM (stage 2).
- Top module: eligibility masking, request routing between stages, output registers.

## Test plan
- Single request: (WEST,1)→NORTH, downstream VC 0, on_off on, held 1 cycle → next cycle read_o[WEST]=2'b10, valid_sel_o[NORTH]=1, input_sel_o[NORTH]=WEST, vc_sel_o[NORTH]=0. All else 0.
- Output contention: NORTH, SOUTH and EAST (VC0) all target LOCAL and are held 6 cycles → grants rotate NORTH, SOUTH, EAST, NORTH, SOUTH, EAST. Exactly one grant per cycle.
- VC contention: both VCs of WEST eligible, VC0→EAST, VC1→NORTH, held → grants alternate VC0/VC1 every cycle. valid_sel_o alternates between EAST and NORTH.
- Flow control: (SOUTH,0)→WEST with downstream VC 1 and on_off_i[WEST][1]=0 for 3 cycles, then 1 → no grant during those 3 cycles, grant 1 cycle after on_off rises.
- iSLIP hold: WEST VC0 loses LOCAL to NORTH → WEST input pointer stays on VC0. It wins LOCAL next cycle before VC1 is served.
- Reset mid-stream: rst asserted between edges during contention → outputs 0 before the next edge. After release, arbitration restarts from index 0 (NORTH first).
